video_stream_framer: RTL and testbench

VIDEO_STREAM_FRAMER -- requirements
Module: video_stream_framer

---
 rtl/video_stream_pkg.sv | 32 +++
 rtl/stream_pos_counter.sv | 49 ++++
 rtl/video_stream_framer.sv | 198 +++++++++++++++++++
 tb/tb_video_stream_framer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_stream_pkg.sv
// ---------------------------------------------------------------------------
// video_stream_pkg
// Shared types and constants for the video stream framer.
//   framer_state_t : framer FSM states (IDLE, LINE, HGAP, VGAP)
//   DEF_*          : default pixel width, frame dimensions and gap lengths
//   FRAME_CNT_W    : width of the optional completed-frame counter
//   cnt_width()    : bits needed to hold 0..n-1, never less than 1
// ---------------------------------------------------------------------------
package video_stream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LINE = 2'd1,
    HGAP = 2'd2,
    VGAP = 2'd3
  } framer_state_t;

  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_FRAME_WIDTH  = 640;
  localparam int DEF_FRAME_HEIGHT = 480;
  localparam int DEF_H_GAP        = 4;
  localparam int DEF_V_GAP        = 16;

  localparam int FRAME_CNT_W = 16;

  // A counter that runs 0..n-1 needs $clog2(n) bits; a 1-value counter
  // still needs a real (1-bit) register.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_pos_counter.sv
// ---------------------------------------------------------------------------
// stream_pos_counter
// Column/line position of the next pixel inside a frame.
//   clk, reset_n : clock, asynchronous active-low reset
//   advance      : one pixel has been accepted this cycle
//   x, y         : column and line of the next pixel to be accepted
//   last_x       : x is the final column of a line
//   last_y       : y is the final line of a frame
// x wraps to 0 after the final column and bumps y; y wraps to 0 after the
// final pixel of the final line.
// ---------------------------------------------------------------------------
module stream_pos_counter
  import video_stream_pkg::*;
#(
  parameter int FRAME_WIDTH  = DEF_FRAME_WIDTH,
  parameter int FRAME_HEIGHT = DEF_FRAME_HEIGHT,
  localparam int X_W = cnt_width(FRAME_WIDTH),
  localparam int Y_W = cnt_width(FRAME_HEIGHT)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           advance,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last_x,
  output logic           last_y
);

  localparam logic [X_W-1:0] X_MAX = X_W'(FRAME_WIDTH - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(FRAME_HEIGHT - 1);

  assign last_x = (x == X_MAX);
  assign last_y = (y == Y_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (last_x) begin
        x <= '0;
        y <= last_y ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/video_stream_framer.sv
// ---------------------------------------------------------------------------
// video_stream_framer
// Accepts a raw pixel stream and re-emits it with line/frame markers, pacing
// the input with idle gaps between lines (H_GAP) and between frames (V_GAP).
//
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   enable_i      : permits a new frame; looked at only at frame boundaries
//   data_i        : raw pixel
//   data_valid_i  : data_i valid
//   ready_o       : framer accepts a pixel this cycle (combinational)
//   data_o        : framed pixel (holds last value when not valid)
//   data_valid_o  : data_o valid
//   sop_o / eop_o : first / last pixel of a line
//   sof_o / eof_o : first / last pixel of a frame
//   frame_cnt_o   : completed-frame count, only with FRAMER_FRAME_CNT_EN
//
// Handshake: a pixel moves when data_valid_i and ready_o are both 1 at a
// rising clk edge. ready_o never depends on data_valid_i. Every transfer
// shows up on data_o/data_valid_o with its markers exactly one cycle later;
// cycles without a transfer produce data_valid_o=0 and no markers.
//
// Optional feature: define FRAMER_FRAME_CNT_EN to add frame_cnt_o, which
// counts eof pixels (wrapping at 2**16) and updates the cycle after eof_o.
//
// The FSM state is kept in the signal 'state' (framer_state_t) so it can be
// observed hierarchically.
// ---------------------------------------------------------------------------
module video_stream_framer
  import video_stream_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int FRAME_WIDTH  = DEF_FRAME_WIDTH,
  parameter int FRAME_HEIGHT = DEF_FRAME_HEIGHT,
  parameter int H_GAP        = DEF_H_GAP,
  parameter int V_GAP        = DEF_V_GAP
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  data_valid_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  data_valid_o,
  output logic                  sop_o,
  output logic                  eop_o,
  output logic                  sof_o,
  output logic                  eof_o
`ifdef FRAMER_FRAME_CNT_EN
  ,
  output logic [FRAME_CNT_W-1:0] frame_cnt_o
`endif
);

  localparam int X_W     = cnt_width(FRAME_WIDTH);
  localparam int Y_W     = cnt_width(FRAME_HEIGHT);
  localparam int GAP_MAX = (H_GAP > V_GAP) ? H_GAP : V_GAP;
  localparam int GAP_W   = cnt_width(GAP_MAX);

  // The gap counter runs 0..GAP-1; these are its terminal values. A zero
  // gap never enters the gap state, so its terminal value is irrelevant.
  localparam logic [GAP_W-1:0] H_LAST = (H_GAP > 0) ? GAP_W'(H_GAP - 1) : '0;
  localparam logic [GAP_W-1:0] V_LAST = (V_GAP > 0) ? GAP_W'(V_GAP - 1) : '0;

  framer_state_t    state;
  framer_state_t    next_state;
  logic             xfer;
  logic [X_W-1:0]   x;
  logic [Y_W-1:0]   y;
  logic             last_x;
  logic             last_y;
  logic [GAP_W-1:0] gap_cnt;
  logic             gap_done;

  // -------------------------------------------------------------------------
  // Handshake
  // -------------------------------------------------------------------------
  assign ready_o = (state == LINE);
  assign xfer    = data_valid_i & ready_o;

  // -------------------------------------------------------------------------
  // Pixel position
  // -------------------------------------------------------------------------
  stream_pos_counter #(
    .FRAME_WIDTH  (FRAME_WIDTH),
    .FRAME_HEIGHT (FRAME_HEIGHT)
  ) u_pos (
    .clk     (clk),
    .reset_n (reset_n),
    .advance (xfer),
    .x       (x),
    .y       (y),
    .last_x  (last_x),
    .last_y  (last_y)
  );

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    gap_done   = 1'b0;
    case (state)
      IDLE: begin
        if (enable_i) begin
          next_state = LINE;
        end
      end
      LINE: begin
        // Only the last pixel of a line can move us out of LINE; a stall
        // (no transfer) keeps everything where it is.
        if (xfer && last_x) begin
          if (last_y) begin
            // End of frame: this is the only place besides IDLE where
            // enable_i matters, so a mid-frame drop cannot cut a frame.
            if (V_GAP > 0) begin
              next_state = VGAP;
            end else begin
              next_state = enable_i ? LINE : IDLE;
            end
          end else if (H_GAP > 0) begin
            next_state = HGAP;
          end
        end
      end
      HGAP: begin
        if (gap_cnt == H_LAST) begin
          gap_done   = 1'b1;
          next_state = LINE;
        end
      end
      VGAP: begin
        if (gap_cnt == V_LAST) begin
          gap_done   = 1'b1;
          next_state = enable_i ? LINE : IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Gap counter: zero outside the gap states, so each gap starts from 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gap_cnt <= '0;
    end else if (((state == HGAP) || (state == VGAP)) && !gap_done) begin
      gap_cnt <= gap_cnt + 1'b1;
    end else begin
      gap_cnt <= '0;
    end
  end

  // -------------------------------------------------------------------------
  // Registered output stage
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_o       <= '0;
      data_valid_o <= 1'b0;
      sop_o        <= 1'b0;
      eop_o        <= 1'b0;
      sof_o        <= 1'b0;
      eof_o        <= 1'b0;
    end else begin
      data_valid_o <= xfer;
      sop_o        <= xfer & (x == '0);
      eop_o        <= xfer & last_x;
      sof_o        <= xfer & (x == '0) & (y == '0);
      eof_o        <= xfer & last_x & last_y;
      if (xfer) begin
        data_o <= data_i;
      end
    end
  end

`ifdef FRAMER_FRAME_CNT_EN
  // Counts completed frames; natural 16-bit wrap from 65535 to 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_o <= '0;
    end else if (eof_o) begin
      frame_cnt_o <= frame_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_video_stream_framer.sv
// ---------------------------------------------------------------------------
// tb_video_stream_framer
// Bench for video_stream_framer. The main instance is a 4x2 frame with
// H_GAP=2, V_GAP=3; a second instance is a 1x1 frame with no gaps.
// A frame-level model (pixel index in frame, remaining idle cycles, frame
// open flag) predicts ready_o and the output pixel/markers every cycle.
// ---------------------------------------------------------------------------
module tb_video_stream_framer;
  import video_stream_pkg::*;

  localparam int DW   = 8;
  localparam int FW   = 4;
  localparam int FH   = 2;
  localparam int HG   = 2;
  localparam int VG   = 3;
  localparam int NPIX = FW * FH;
  localparam int W    = DW + 4;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance signals
  logic          enable_i     = 1'b0;
  logic [DW-1:0] data_i       = 8'h05;
  logic          data_valid_i = 1'b0;
  logic          ready_o;
  logic [DW-1:0] data_o;
  logic          data_valid_o;
  logic          sop_o, eop_o, sof_o, eof_o;

  // 1x1 instance signals
  logic          one_en    = 1'b0;
  logic [DW-1:0] one_data  = 8'h21;
  logic          one_valid = 1'b0;
  logic          one_ready;
  logic [DW-1:0] one_data_o;
  logic          one_valid_o;
  logic          one_sop, one_eop, one_sof, one_eof;
  logic [DW-1:0] one_prev;

`ifdef FRAMER_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] frame_cnt_o;
  logic [FRAME_CNT_W-1:0] one_frame_cnt;
`endif

  video_stream_framer #(
    .DATA_WIDTH (DW), .FRAME_WIDTH (FW), .FRAME_HEIGHT (FH),
    .H_GAP (HG), .V_GAP (VG)
  ) u_dut (
    .clk (clk), .reset_n (reset_n), .enable_i (enable_i),
    .data_i (data_i), .data_valid_i (data_valid_i), .ready_o (ready_o),
    .data_o (data_o), .data_valid_o (data_valid_o),
    .sop_o (sop_o), .eop_o (eop_o), .sof_o (sof_o), .eof_o (eof_o)
`ifdef FRAMER_FRAME_CNT_EN
    , .frame_cnt_o (frame_cnt_o)
`endif
  );

  video_stream_framer #(
    .DATA_WIDTH (DW), .FRAME_WIDTH (1), .FRAME_HEIGHT (1),
    .H_GAP (0), .V_GAP (0)
  ) u_one (
    .clk (clk), .reset_n (reset_n), .enable_i (one_en),
    .data_i (one_data), .data_valid_i (one_valid), .ready_o (one_ready),
    .data_o (one_data_o), .data_valid_o (one_valid_o),
    .sop_o (one_sop), .eop_o (one_eop), .sof_o (one_sof), .eof_o (one_eof)
`ifdef FRAMER_FRAME_CNT_EN
    , .frame_cnt_o (one_frame_cnt)
`endif
  );

  // -------------------------------------------------------------------------
  // Check helper and counters
  // -------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Scoreboard: frame-level model + expected queue
  // Entry layout: {sof, sop, eop, eof, data}
  // -------------------------------------------------------------------------
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  e;
  logic [DW-1:0] last_data = '0;
  int            m_pix  = 0;    // index of next pixel within the frame
  int            m_wait = 0;    // idle cycles still to go before ready
  bit            m_open = 1'b0; // a frame is in progress (or about to start)
  int            mx, my;

  // Observation records used by the literal checks
  logic [3:0] obs_q[$];
  int         low_q[$];
  int         low_run   = 0;
  bit         seen_high = 1'b0;

  always @(negedge clk) begin
    if (!reset_n) begin
      check("rst_valid", 32'(data_valid_o), 0);
      check("rst_marks", 32'({sof_o, sop_o, eop_o, eof_o}), 0);
      check("rst_data", 32'(data_o), 0);
      check("rst_ready", 32'(ready_o), 0);
      exp_q.delete();
      last_data = '0;
      m_pix     = 0;
      m_wait    = 0;
      m_open    = 1'b0;
      low_run   = 0;
      seen_high = 1'b0;
    end else begin
      // Outputs produced by the previous edge
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out_valid", 32'(data_valid_o), 1);
        check("out_marks", 32'({sof_o, sop_o, eop_o, eof_o}), 32'(e[W-1:DW]));
        check("out_data", 32'(data_o), 32'(e[DW-1:0]));
        last_data = e[DW-1:0];
      end else begin
        check("idle_valid", 32'(data_valid_o), 0);
        check("idle_marks", 32'({sof_o, sop_o, eop_o, eof_o}), 0);
        check("idle_data_hold", 32'(data_o), 32'(last_data));
      end
      check("ready", 32'(ready_o), 32'(m_open && (m_wait == 0)));

      if (data_valid_o) obs_q.push_back({sof_o, sop_o, eop_o, eof_o});
      if (ready_o) begin
        if (seen_high && (low_run > 0)) low_q.push_back(low_run);
        low_run   = 0;
        seen_high = 1'b1;
      end else begin
        low_run++;
      end

      // Advance the model across the coming edge
      if (m_open && (m_wait == 0)) begin
        if (data_valid_i) begin
          mx = m_pix % FW;
          my = m_pix / FW;
          exp_q.push_back({(mx == 0) && (my == 0), mx == 0, mx == FW - 1,
                           (mx == FW - 1) && (my == FH - 1), data_i});
          m_pix++;
          if (m_pix == NPIX) begin
            m_pix  = 0;
            m_open = 1'b0;
            m_wait = VG;
            if (VG == 0) m_open = enable_i;
          end else if (mx == FW - 1) begin
            m_wait = HG;
          end
        end
      end else begin
        if (m_wait > 0) m_wait--;
        if (!m_open && (m_wait == 0)) m_open = enable_i;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      data_i = data_i + 8'h13;
    end
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    enable_i     = 1'b0;
    data_valid_i = 1'b0;
    one_en       = 1'b0;
    one_valid    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic clear_obs();
    obs_q.delete();
    low_q.delete();
  endtask

  task automatic check_frame_marks(input string tag);
    logic [3:0] mk_exp [NPIX];
    mk_exp = '{4'b1100, 4'b0000, 4'b0000, 4'b0010,
               4'b0100, 4'b0000, 4'b0000, 4'b0011};
    check({tag, "_npix"}, 32'(obs_q.size() >= NPIX), 1);
    if (obs_q.size() >= NPIX) begin
      for (int i = 0; i < NPIX; i++) begin
        check($sformatf("%s_mark%0d", tag, i), 32'(obs_q[i]), 32'(mk_exp[i]));
      end
    end
  endtask

  // -------------------------------------------------------------------------
  // Directed scenarios
  // -------------------------------------------------------------------------
  initial begin
    #2;
    check("t0_ready", 32'(ready_o), 0);
    check("t0_valid", 32'(data_valid_o), 0);
    check("t0_data", 32'(data_o), 0);
    do_reset();

    // A: continuous valid, full frame with both gaps
    clear_obs();
    enable_i     = 1'b1;
    data_valid_i = 1'b1;
    cycles(18);
    check_frame_marks("A");
    check("A_nruns", 32'(low_q.size() >= 2), 1);
    if (low_q.size() >= 2) begin
      check("A_hgap_len", 32'(low_q[0]), 2);
      check("A_vgap_len", 32'(low_q[1]), 3);
    end

    // B: valid toggling every cycle, enable dropped mid-frame
    do_reset();
    clear_obs();
    enable_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      data_valid_i = ~data_valid_i;
      if (i == 4) enable_i = 1'b0;
      cycles(1);
    end
    check("B_count", 32'(obs_q.size()), NPIX);
    check_frame_marks("B");
    check("B_ready_end", 32'(ready_o), 0);

    // C: enable dropped after 3 pixels; frame completes, then IDLE
    do_reset();
    clear_obs();
    enable_i     = 1'b1;
    data_valid_i = 1'b1;
    cycles(4);
    enable_i = 1'b0;
    cycles(30);
    check("C_count", 32'(obs_q.size()), NPIX);
    check_frame_marks("C");
    check("C_ready_end", 32'(ready_o), 0);

    // D: asynchronous reset at pixel 5, then a clean frame
    do_reset();
    clear_obs();
    enable_i     = 1'b1;
    data_valid_i = 1'b1;
    for (int i = 0; i < 60 && obs_q.size() < 5; i++) cycles(1);
    check("D_reach5", 32'(obs_q.size() >= 5), 1);
    #1 reset_n = 1'b0;
    #1;
    check("D_async_ready", 32'(ready_o), 0);
    check("D_async_valid", 32'(data_valid_o), 0);
    check("D_async_marks", 32'({sof_o, sop_o, eop_o, eof_o}), 0);
    check("D_async_data", 32'(data_o), 0);
`ifdef FRAMER_FRAME_CNT_EN
    check("D_async_fcnt", 32'(frame_cnt_o), 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    clear_obs();
    for (int i = 0; i < 20 && obs_q.size() < 1; i++) cycles(1);
    check("D_first_seen", 32'(obs_q.size() >= 1), 1);
    if (obs_q.size() >= 1) check("D_first_marks", 32'(obs_q[0]), 32'(4'b1100));
`ifdef FRAMER_FRAME_CNT_EN
    check("D_fcnt_before", 32'(frame_cnt_o), 0);
`endif
    for (int i = 0; i < 40 && obs_q.size() < NPIX; i++) cycles(1);
    check_frame_marks("D");
`ifdef FRAMER_FRAME_CNT_EN
    check("D_fcnt_after", 32'(frame_cnt_o), 1);
`endif
    enable_i = 1'b0;
    cycles(10);

    // E: 1x1 frame, no gaps: every pixel carries all four markers
    do_reset();
    one_en    = 1'b1;
    one_valid = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      one_prev = one_data;
      one_data = one_data + 8'h11;
      @(negedge clk);
      check("E_ready", 32'(one_ready), 1);
      check("E_valid", 32'(one_valid_o), 1);
      check("E_marks", 32'({one_sof, one_sop, one_eop, one_eof}), 32'(4'b1111));
      check("E_data", 32'(one_data_o), 32'(one_prev));
    end
    one_en    = 1'b0;
    one_valid = 1'b0;
    cycles(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
